coo_matmul_scheduler: RTL and testbench

- Sequences the sparse COO matrix-multiply datapath. It buffers COO entries of A and B loaded over a valid/ready stream.
- On start, it pulses an accumulator clear and then scans every (A entry, B entry) pair. Only pairs with A.col == B.row are issued to the FP8 multiply-accumulate PE over a valid/ready handshake.
- The block sits between the host/loader and the MAC array. It replaces the free-running all-pairs loop with a bounded, back-pressurable schedule.

---
 rtl/coo_pkg.sv | 25 ++
 rtl/coo_entry_buf.sv | 39 +++
 rtl/coo_matmul_scheduler.sv | 140 ++++++++++++++
 tb/tb_coo_matmul_scheduler.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/coo_pkg.sv
// Shared sizes, the COO entry record and the scheduler state encoding.
package coo_pkg;

  localparam int NNZ   = 32;
  localparam int DIM   = 8;
  localparam int IDXW  = 3;
  localparam int DW    = 8;
  localparam int CNTW  = 11;
  localparam int PTRW  = $clog2(NNZ);
  localparam int FILLW = $clog2(NNZ + 1);

  typedef struct packed {
    logic [IDXW-1:0] row;
    logic [IDXW-1:0] col;
    logic [DW-1:0]   data;
  } coo_entry_t;

  typedef enum logic [1:0] {
    IDLE,
    CLEAR,
    SCAN,
    DONE
  } state_t;

endpackage

// File: rtl/coo_entry_buf.sv
// Append-only COO entry store with a fill count and an asynchronous read port.
module coo_entry_buf
  import coo_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic             clr,
  input  coo_entry_t       wr_entry,
  input  logic [PTRW-1:0]  rd_idx,
  output coo_entry_t       rd_entry,
  output logic [FILLW-1:0] count,
  output logic             full
);

  coo_entry_t mem [NNZ];

  assign full     = (count == FILLW'(NNZ));
  assign rd_entry = mem[rd_idx];

  // Fill count: cleared once a run has consumed the buffer, bumped on each accepted write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (wr_en && !full) begin
      count <= count + FILLW'(1);
    end
  end

  // Entry storage: new entries land at the current fill position; contents need no reset.
  always_ff @(posedge clk) begin
    if (wr_en && !full) begin
      mem[count[PTRW-1:0]] <= wr_entry;
    end
  end

endmodule

// File: rtl/coo_matmul_scheduler.sv
// Buffers COO entries of A and B, then issues every matching (A, B) pair to the MAC PE.
module coo_matmul_scheduler
  import coo_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            ld_valid,
  output logic            ld_ready,
  input  logic            ld_sel,
  input  logic [IDXW-1:0] ld_row,
  input  logic [IDXW-1:0] ld_col,
  input  logic [DW-1:0]   ld_data,
  input  logic            start,
  output logic            busy,
  output logic            done,
  output logic            acc_clr,
  output logic            pe_valid,
  input  logic            pe_ready,
  output logic [DW-1:0]   pe_a,
  output logic [DW-1:0]   pe_b,
  output logic [IDXW-1:0] pe_row,
  output logic [IDXW-1:0] pe_col,
  output logic [CNTW-1:0] pair_cnt
);

  state_t           state, state_nxt;
  logic [PTRW-1:0]  i_idx, j_idx;
  logic [FILLW-1:0] a_cnt, b_cnt;
  coo_entry_t       ld_entry, a_entry, b_entry;
  logic             a_full, b_full, a_wr, b_wr, buf_clr;
  logic             match, last_j, last_pair, advance;

  assign ld_entry = '{row: ld_row, col: ld_col, data: ld_data};
  assign ld_ready = (state == IDLE) && !(ld_sel ? b_full : a_full);
  assign a_wr     = ld_valid && ld_ready && !ld_sel;
  assign b_wr     = ld_valid && ld_ready && ld_sel;
  assign buf_clr  = (state == DONE);

  coo_entry_buf u_a_buf (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (a_wr),
    .clr      (buf_clr),
    .wr_entry (ld_entry),
    .rd_idx   (i_idx),
    .rd_entry (a_entry),
    .count    (a_cnt),
    .full     (a_full)
  );

  coo_entry_buf u_b_buf (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (b_wr),
    .clr      (buf_clr),
    .wr_entry (ld_entry),
    .rd_idx   (j_idx),
    .rd_entry (b_entry),
    .count    (b_cnt),
    .full     (b_full)
  );

  assign match     = (a_entry.col == b_entry.row);
  assign last_j    = (FILLW'(j_idx) == b_cnt - FILLW'(1));
  assign last_pair = last_j && (FILLW'(i_idx) == a_cnt - FILLW'(1));

  assign pe_a   = a_entry.data;
  assign pe_b   = b_entry.data;
  assign pe_row = a_entry.row;
  assign pe_col = b_entry.col;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and control outputs; a stalled request holds because i/j only move on advance.
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    acc_clr   = 1'b0;
    pe_valid  = 1'b0;
    advance   = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = CLEAR;
        end
      end
      CLEAR: begin
        busy      = 1'b1;
        acc_clr   = 1'b1;
        state_nxt = ((a_cnt == '0) || (b_cnt == '0)) ? DONE : SCAN;
      end
      SCAN: begin
        busy     = 1'b1;
        pe_valid = match;
        advance  = !match || pe_ready;
        if (advance && last_pair) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        busy      = 1'b1;
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Pair walker (A-major, B-minor) and issued-product counter, both restarted when a run begins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      i_idx    <= '0;
      j_idx    <= '0;
      pair_cnt <= '0;
    end else if ((state == IDLE) && start) begin
      i_idx    <= '0;
      j_idx    <= '0;
      pair_cnt <= '0;
    end else if (advance) begin
      if (pe_valid) begin
        pair_cnt <= pair_cnt + CNTW'(1);
      end
      if (last_j) begin
        j_idx <= '0;
        i_idx <= i_idx + PTRW'(1);
      end else begin
        j_idx <= j_idx + PTRW'(1);
      end
    end
  end

endmodule

// File: tb/tb_coo_matmul_scheduler.sv
// Self-checking bench for coo_matmul_scheduler: directed vector table, corner sequences, random runs.
module tb_coo_matmul_scheduler;
  import coo_pkg::*;

  logic            clk = 1'b0;
  logic            rst;
  logic            ld_valid, ld_ready, ld_sel;
  logic [IDXW-1:0] ld_row, ld_col;
  logic [DW-1:0]   ld_data;
  logic            start, busy, done, acc_clr;
  logic            pe_valid, pe_ready;
  logic [DW-1:0]   pe_a, pe_b;
  logic [IDXW-1:0] pe_row, pe_col;
  logic [CNTW-1:0] pair_cnt;

  typedef struct {
    logic [IDXW-1:0] row;
    logic [IDXW-1:0] col;
    logic [DW-1:0]   a;
    logic [DW-1:0]   b;
  } issue_t;

  typedef struct {
    logic [IDXW-1:0] aRow;
    logic [IDXW-1:0] aCol;
    logic [DW-1:0]   aData;
    logic [IDXW-1:0] bRow;
    logic [IDXW-1:0] bCol;
    logic [DW-1:0]   bData;
    int              expPairs;
    int              expDone;
  } vec_t;

  coo_entry_t modelA[$];
  coo_entry_t modelB[$];
  vec_t       vecs[4];
  int         tests = 0;
  int         fails = 0;
  int         obsPairs, obsDone, na, nb;

  coo_matmul_scheduler dut (
    .clk      (clk),
    .rst      (rst),
    .ld_valid (ld_valid),
    .ld_ready (ld_ready),
    .ld_sel   (ld_sel),
    .ld_row   (ld_row),
    .ld_col   (ld_col),
    .ld_data  (ld_data),
    .start    (start),
    .busy     (busy),
    .done     (done),
    .acc_clr  (acc_clr),
    .pe_valid (pe_valid),
    .pe_ready (pe_ready),
    .pe_a     (pe_a),
    .pe_b     (pe_b),
    .pe_row   (pe_row),
    .pe_col   (pe_col),
    .pair_cnt (pair_cnt)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int actual, input int expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Presents one load entry; acceptance is predicted from the model's fill level.
  task automatic applyStimulus(input logic sel, input logic [IDXW-1:0] row,
                               input logic [IDXW-1:0] col, input logic [DW-1:0] data);
    bit expReady;
    @(negedge clk);
    ld_valid = 1'b1;
    ld_sel   = sel;
    ld_row   = row;
    ld_col   = col;
    ld_data  = data;
    expReady = sel ? (modelB.size() < NNZ) : (modelA.size() < NNZ);
    #1 checkOutput("ld_ready", int'(ld_ready), int'(expReady));
    if (expReady) begin
      if (sel) modelB.push_back('{row, col, data});
      else     modelA.push_back('{row, col, data});
    end
  endtask

  // Starts a run and checks every issued product, acc_clr timing, done timing and pair_cnt.
  // mode 0: pe_ready high; mode 1: first request stalled 3 cycles; mode 2: random pe_ready.
  task automatic runScan(input int mode, input string name, output int pairsOut, output int doneOut);
    issue_t expQ[$];
    int     cyc, stalls, expPairs, expDone, stallLeft;
    bit     finished;
    foreach (modelA[ia])
      foreach (modelB[jb])
        if (modelA[ia].col == modelB[jb].row)
          expQ.push_back('{modelA[ia].row, modelB[jb].col, modelA[ia].data, modelB[jb].data});
    expPairs  = expQ.size();
    expDone   = 2 + modelA.size() * modelB.size();
    stallLeft = (mode == 1) ? 3 : 0;
    stalls    = 0;
    cyc       = 0;
    finished  = 1'b0;
    pairsOut  = -1;
    doneOut   = -1;
    @(negedge clk);
    ld_valid = 1'b0;
    start    = 1'b1;
    pe_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (!finished && cyc < 4000) begin
      cyc++;
      if (cyc <= 2) checkOutput({name, " acc_clr"}, int'(acc_clr), int'(cyc == 1));
      if (expQ.size() == 0) checkOutput({name, " pe_valid idle"}, int'(pe_valid), 0);
      if (pe_valid && expQ.size() > 0) begin
        checkOutput({name, " pe_row"}, int'(pe_row), int'(expQ[0].row));
        checkOutput({name, " pe_col"}, int'(pe_col), int'(expQ[0].col));
        checkOutput({name, " pe_a"}, int'(pe_a), int'(expQ[0].a));
        checkOutput({name, " pe_b"}, int'(pe_b), int'(expQ[0].b));
        if (mode == 1 && stallLeft > 0) begin
          pe_ready = 1'b0;
          stallLeft--;
        end else if (mode == 2) begin
          pe_ready = 1'($urandom_range(0, 1));
        end else begin
          pe_ready = 1'b1;
        end
        if (pe_ready) void'(expQ.pop_front());
        else stalls++;
      end
      if (done) begin
        finished = 1'b1;
        doneOut  = cyc;
        pairsOut = int'(pair_cnt);
        checkOutput({name, " done cycle"}, cyc, expDone + stalls);
        checkOutput({name, " pair_cnt"}, int'(pair_cnt), expPairs);
        checkOutput({name, " busy at done"}, int'(busy), 1);
        checkOutput({name, " issues left"}, expQ.size(), 0);
      end else begin
        @(negedge clk);
      end
    end
    if (!finished) checkOutput({name, " done seen"}, int'(done), 1);
    @(negedge clk);
    checkOutput({name, " ld_ready after run"}, int'(ld_ready), 1);
    checkOutput({name, " pair_cnt held"}, int'(pair_cnt), expPairs);
    pe_ready = 1'b1;
    modelA.delete();
    modelB.delete();
  endtask

  task automatic runVector(input vec_t v, input string name);
    int p, d;
    applyStimulus(1'b0, v.aRow, v.aCol, v.aData);
    applyStimulus(1'b1, v.bRow, v.bCol, v.bData);
    runScan(0, name, p, d);
    checkOutput({name, " table pairs"}, p, v.expPairs);
    checkOutput({name, " table done"}, d, v.expDone);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    vecs[0] = '{3'd0, 3'd1, 8'h38, 3'd1, 3'd2, 8'h40, 1, 3};
    vecs[1] = '{3'd0, 3'd3, 8'h38, 3'd4, 3'd0, 8'h38, 0, 3};
    vecs[2] = '{3'd7, 3'd7, 8'hC8, 3'd7, 3'd0, 8'h01, 1, 3};
    vecs[3] = '{3'd2, 3'd5, 8'h10, 3'd6, 3'd5, 8'h20, 0, 3};

    rst      = 1'b1;
    ld_valid = 1'b0;
    ld_sel   = 1'b0;
    ld_row   = '0;
    ld_col   = '0;
    ld_data  = '0;
    start    = 1'b0;
    pe_ready = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset busy", int'(busy), 0);
    checkOutput("reset done", int'(done), 0);
    checkOutput("reset acc_clr", int'(acc_clr), 0);
    checkOutput("reset pe_valid", int'(pe_valid), 0);
    checkOutput("reset ld_ready", int'(ld_ready), 1);
    checkOutput("reset pair_cnt", int'(pair_cnt), 0);
    rst = 1'b0;

    for (int v = 0; v < 4; v++) runVector(vecs[v], $sformatf("vec%0d", v));

    // Two A entries in column 1 against two B entries in row 1, first request stalled.
    applyStimulus(1'b0, 3'd0, 3'd1, 8'h38);
    applyStimulus(1'b0, 3'd1, 3'd1, 8'h40);
    applyStimulus(1'b1, 3'd1, 3'd0, 8'h48);
    applyStimulus(1'b1, 3'd1, 3'd2, 8'h30);
    runScan(1, "stall", obsPairs, obsDone);
    checkOutput("stall pairs", obsPairs, 4);
    checkOutput("stall done", obsDone, 9);

    // Overfill A: 33rd load refused, B still accepted in the same state.
    for (int k = 0; k < 33; k++)
      applyStimulus(1'b0, 3'(k % 8), 3'(k % 3), 8'(k + 1));
    checkOutput("full A ld_ready", int'(ld_ready), 0);
    applyStimulus(1'b1, 3'd1, 3'd4, 8'h55);
    runScan(2, "full", obsPairs, obsDone);

    // A loaded, B empty: clear pulse and straight to done.
    for (int k = 0; k < 3; k++) applyStimulus(1'b0, 3'(k), 3'd1, 8'h38);
    runScan(0, "emptyB", obsPairs, obsDone);
    checkOutput("emptyB done", obsDone, 2);
    checkOutput("emptyB pairs", obsPairs, 0);

    // Asynchronous reset while a request is pending.
    applyStimulus(1'b0, 3'd0, 3'd1, 8'h38);
    applyStimulus(1'b0, 3'd3, 3'd1, 8'h50);
    applyStimulus(1'b1, 3'd1, 3'd2, 8'h40);
    @(negedge clk);
    ld_valid = 1'b0;
    start    = 1'b1;
    pe_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 10 && pair_cnt == 0; k++) @(negedge clk);
    pe_ready = 1'b0;
    checkOutput("rst pre pe_valid", int'(pe_valid), 1);
    checkOutput("rst pre pair_cnt", int'(pair_cnt), 1);
    #2 rst = 1'b1;
    #1;
    checkOutput("rst pe_valid", int'(pe_valid), 0);
    checkOutput("rst busy", int'(busy), 0);
    checkOutput("rst pair_cnt", int'(pair_cnt), 0);
    @(negedge clk);
    rst = 1'b0;
    #1 checkOutput("rst ld_ready", int'(ld_ready), 1);
    pe_ready = 1'b1;
    modelA.delete();
    modelB.delete();
    runVector(vecs[0], "after rst");

    // Randomised runs against the pair-enumeration model.
    for (int r = 0; r < 8; r++) begin
      na = int'($urandom_range(0, 8));
      nb = int'($urandom_range(0, 8));
      for (int k = 0; k < na; k++)
        applyStimulus(1'b0, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 3)), 8'($urandom_range(0, 255)));
      for (int k = 0; k < nb; k++)
        applyStimulus(1'b1, 3'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), 8'($urandom_range(0, 255)));
      runScan(2, $sformatf("rand%0d", r), obsPairs, obsDone);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
